bank_rd_ret: RTL and testbench

- Response-side companion to the two-bank request splitter.
- Accepts one logical read and one logical write per cycle against a memory built from two single-port RAM banks, interleaved on the address LSB.
- Returns read data one cycle after the request.
- When a write collides with a read on the same bank, parks the write in an in-order replay queue and drains it on later free bank cycles. Reads of queued addresses are forwarded from the queue.

---
 rtl/bank_rd_ret_pkg.sv | 16 +
 rtl/bank_rd_ret_wr_replay_q.sv | 97 +++++++++
 rtl/bank_rd_ret.sv | 174 +++++++++++++++++
 tb/tb_bank_rd_ret.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bank_rd_ret_pkg.sv
// rtl/bank_rd_ret_pkg.sv - shared parameters for the two-bank read-return block
// Purpose: default widths, bank-select bit position and the replay-queue pointer sizing helper.
package bank_rd_ret_pkg;

    localparam int DEF_A_W     = 8;
    localparam int DEF_D_W     = 32;
    localparam int DEF_Q_DEPTH = 2;
    // Address bit that picks the bank; the remaining upper bits form the bank word address.
    localparam int BANK_BIT    = 0;

    // Pointer width for a circular buffer of the given depth (never zero bits).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bank_rd_ret_wr_replay_q.sv
// rtl/bank_rd_ret_wr_replay_q.sv - in-order replay queue for writes that lost bank arbitration
// Purpose: circular FIFO of (address, data) write entries with an occupancy counter and an
//          associative address lookup returning the youngest matching entry.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   i_push, i_push_adr, i_push_data   enqueue at tail (caller guarantees not full)
//   i_pop                             dequeue head (caller guarantees not empty)
//   o_head_vld, o_head_adr, o_head_data  oldest entry
//   o_cnt, o_full                     occupancy
//   i_match_adr, o_hit, o_hit_data    youngest entry matching i_match_adr, head excluded while popping
module bank_rd_ret_wr_replay_q
    import bank_rd_ret_pkg::*;
#(
    parameter int A_W     = DEF_A_W,
    parameter int D_W     = DEF_D_W,
    parameter int Q_DEPTH = DEF_Q_DEPTH,
    parameter int CW      = $clog2(Q_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_push,
    input  logic [A_W-1:0] i_push_adr,
    input  logic [D_W-1:0] i_push_data,
    input  logic           i_pop,
    output logic           o_head_vld,
    output logic [A_W-1:0] o_head_adr,
    output logic [D_W-1:0] o_head_data,
    output logic [CW-1:0]  o_cnt,
    output logic           o_full,
    input  logic [A_W-1:0] i_match_adr,
    output logic           o_hit,
    output logic [D_W-1:0] o_hit_data
);

    localparam int PW = ptr_w(Q_DEPTH);

    logic [A_W-1:0] r_adr  [Q_DEPTH];
    logic [D_W-1:0] r_data [Q_DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_cnt;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(Q_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_tail <= ptr_next(r_tail);
            if (i_pop)  r_head <= ptr_next(r_head);
            unique case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_adr[r_tail]  <= i_push_adr;
            r_data[r_tail] <= i_push_data;
        end
    end

    assign o_head_vld  = (r_cnt != '0);
    assign o_head_adr  = r_adr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_cnt       = r_cnt;
    assign o_full      = (r_cnt == CW'(Q_DEPTH));

    // Walk from oldest to youngest so the last hit wins. The head is skipped while it is
    // being written to the RAM this cycle, since the bank then holds that value.
    always_comb begin
        logic [PW:0]   v_sum;
        logic [PW-1:0] v_idx;
        o_hit      = 1'b0;
        o_hit_data = '0;
        v_sum      = '0;
        v_idx      = '0;
        for (int k = 0; k < Q_DEPTH; k++) begin
            v_sum = {1'b0, r_head} + (PW+1)'(k);
            if (v_sum >= (PW+1)'(Q_DEPTH)) v_sum = v_sum - (PW+1)'(Q_DEPTH);
            v_idx = v_sum[PW-1:0];
            if ((k < int'(r_cnt)) && !((k == 0) && i_pop) && (r_adr[v_idx] == i_match_adr)) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[v_idx];
            end
        end
    end

endmodule

// File: rtl/bank_rd_ret.sv
// rtl/bank_rd_ret.sv - two-bank memory front end with write replay queue and 1-cycle read return
// Purpose: arbitrates one read and one write per cycle across two LSB-interleaved single-port
//          RAM banks (read > queued write > new write), parks colliding writes in an in-order
//          replay queue, forwards queued data to reads, and returns read data one cycle later.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   RD_REQ, RD_ADR                 read request
//   WR_REQ, WR_ADR, WR_DATA, WR_RDY  write request, accepted while WR_RDY=1
//   RD_VALID, RD_DATA              read return
//   PEND_CNT                       queued write count
//   ENABLE_b, WE_b, A_b, D_b, DO_b bank b RAM port (registered read data on DO_b)
module bank_rd_ret
    import bank_rd_ret_pkg::*;
#(
    parameter int A_W     = DEF_A_W,
    parameter int D_W     = DEF_D_W,
    parameter int Q_DEPTH = DEF_Q_DEPTH,
    parameter int CW      = $clog2(Q_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RD_REQ,
    input  logic [A_W-1:0] RD_ADR,
    input  logic           WR_REQ,
    input  logic [A_W-1:0] WR_ADR,
    input  logic [D_W-1:0] WR_DATA,
    output logic           WR_RDY,
    output logic           RD_VALID,
    output logic [D_W-1:0] RD_DATA,
    output logic [CW-1:0]  PEND_CNT,
    output logic           ENABLE_0,
    output logic           WE_0,
    output logic [A_W-2:0] A_0,
    output logic [D_W-1:0] D_0,
    input  logic [D_W-1:0] DO_0,
    output logic           ENABLE_1,
    output logic           WE_1,
    output logic [A_W-2:0] A_1,
    output logic [D_W-1:0] D_1,
    input  logic [D_W-1:0] DO_1
);

    logic           w_rd_bank;
    logic           w_rd_go;
    logic           w_busy0;
    logic           w_busy1;
    logic           w_head_vld;
    logic [A_W-1:0] w_head_adr;
    logic [D_W-1:0] w_head_data;
    logic           w_head_go;
    logic           w_full;
    logic           w_wr_acc;
    logic           w_byp;
    logic           w_push;
    logic           w_wr_go;
    logic           w_wr_bank;
    logic [A_W-2:0] w_wr_wadr;
    logic [D_W-1:0] w_wr_data;
    logic           w_hit;
    logic [D_W-1:0] w_hit_data;

    logic           r_rd_valid;
    logic           r_bank;
    logic           r_fwd;
    logic [D_W-1:0] r_fwd_data;
    logic [D_W-1:0] r_hold;

    bank_rd_ret_wr_replay_q #(
        .A_W     (A_W),
        .D_W     (D_W),
        .Q_DEPTH (Q_DEPTH),
        .CW      (CW)
    ) u_q (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_adr  (WR_ADR),
        .i_push_data (WR_DATA),
        .i_pop       (w_head_go),
        .o_head_vld  (w_head_vld),
        .o_head_adr  (w_head_adr),
        .o_head_data (w_head_data),
        .o_cnt       (PEND_CNT),
        .o_full      (w_full),
        .i_match_adr (RD_ADR),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data)
    );

    assign WR_RDY = !w_full;

    // Bank ports are held quiet for the whole time reset is asserted.
    assign w_rd_bank = RD_ADR[BANK_BIT];
    assign w_rd_go   = RD_REQ && rst;
    assign w_busy0   = w_rd_go && !w_rd_bank;
    assign w_busy1   = w_rd_go &&  w_rd_bank;

    assign w_head_go = w_head_vld && rst &&
                       !(w_head_adr[BANK_BIT] ? w_busy1 : w_busy0);

    // A new write may only bypass an empty queue; otherwise it lines up behind it, keeping order.
    assign w_wr_acc = WR_REQ && WR_RDY && rst;
    assign w_byp    = w_wr_acc && !w_head_vld &&
                      !(WR_ADR[BANK_BIT] ? w_busy1 : w_busy0);
    assign w_push   = w_wr_acc && !w_byp;

    assign w_wr_go   = w_head_go || w_byp;
    assign w_wr_bank = w_head_go ? w_head_adr[BANK_BIT] : WR_ADR[BANK_BIT];
    assign w_wr_wadr = w_head_go ? w_head_adr[A_W-1:1]  : WR_ADR[A_W-1:1];
    assign w_wr_data = w_head_go ? w_head_data          : WR_DATA;

    // The issued write always targets the bank the read leaves free, so the two never overlap.
    always_comb begin
        ENABLE_0 = 1'b0;
        WE_0     = 1'b0;
        A_0      = '0;
        D_0      = '0;
        ENABLE_1 = 1'b0;
        WE_1     = 1'b0;
        A_1      = '0;
        D_1      = '0;
        if (w_busy0) begin
            ENABLE_0 = 1'b1;
            A_0      = RD_ADR[A_W-1:1];
        end
        if (w_busy1) begin
            ENABLE_1 = 1'b1;
            A_1      = RD_ADR[A_W-1:1];
        end
        if (w_wr_go && !w_wr_bank) begin
            ENABLE_0 = 1'b1;
            WE_0     = 1'b1;
            A_0      = w_wr_wadr;
            D_0      = w_wr_data;
        end
        if (w_wr_go && w_wr_bank) begin
            ENABLE_1 = 1'b1;
            WE_1     = 1'b1;
            A_1      = w_wr_wadr;
            D_1      = w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_bank     <= 1'b0;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
            r_hold     <= '0;
        end else begin
            r_rd_valid <= RD_REQ;
            if (RD_REQ) begin
                r_bank     <= w_rd_bank;
                r_fwd      <= w_hit;
                r_fwd_data <= w_hit_data;
            end
            // Remember the returned word so RD_DATA stays put between reads.
            if (r_rd_valid) r_hold <= RD_DATA;
        end
    end

    assign RD_VALID = r_rd_valid;

    always_comb begin
        RD_DATA = r_hold;
        if (r_rd_valid) begin
            if (r_fwd)       RD_DATA = r_fwd_data;
            else if (r_bank) RD_DATA = DO_1;
            else             RD_DATA = DO_0;
        end
    end

endmodule

// File: tb/tb_bank_rd_ret.sv
// tb/tb_bank_rd_ret.sv - self-checking bench for bank_rd_ret
module tb_bank_rd_ret;

    localparam int A_W = 8;
    localparam int D_W = 32;
    localparam int QD  = 2;

    typedef struct {
        logic [A_W-1:0] adr;
        logic [D_W-1:0] data;
    } wr_t;

    logic           clk;
    logic           rst;
    logic           RD_REQ;
    logic [A_W-1:0] RD_ADR;
    logic           WR_REQ;
    logic [A_W-1:0] WR_ADR;
    logic [D_W-1:0] WR_DATA;
    logic           WR_RDY;
    logic           RD_VALID;
    logic [D_W-1:0] RD_DATA;
    logic [1:0]     PEND_CNT;
    logic           ENABLE_0, WE_0, ENABLE_1, WE_1;
    logic [A_W-2:0] A_0, A_1;
    logic [D_W-1:0] D_0, D_1, DO_0, DO_1;

    logic [D_W-1:0] mem0 [128];
    logic [D_W-1:0] mem1 [128];

    wr_t            q[$];
    logic [D_W-1:0] ref_ram [256];
    logic [D_W-1:0] last_rd;
    int             n_chk;
    int             n_fail;

    bank_rd_ret #(.A_W(A_W), .D_W(D_W), .Q_DEPTH(QD)) dut (
        .clk      (clk),
        .rst      (rst),
        .RD_REQ   (RD_REQ),
        .RD_ADR   (RD_ADR),
        .WR_REQ   (WR_REQ),
        .WR_ADR   (WR_ADR),
        .WR_DATA  (WR_DATA),
        .WR_RDY   (WR_RDY),
        .RD_VALID (RD_VALID),
        .RD_DATA  (RD_DATA),
        .PEND_CNT (PEND_CNT),
        .ENABLE_0 (ENABLE_0),
        .WE_0     (WE_0),
        .A_0      (A_0),
        .D_0      (D_0),
        .DO_0     (DO_0),
        .ENABLE_1 (ENABLE_1),
        .WE_1     (WE_1),
        .A_1      (A_1),
        .D_1      (D_1),
        .DO_1     (DO_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port RAM banks.
    always @(posedge clk) begin
        if (ENABLE_0) begin
            if (WE_0) mem0[A_0] = D_0;
            else      DO_0 <= mem0[A_0];
        end
        if (ENABLE_1) begin
            if (WE_1) mem1[A_1] = D_1;
            else      DO_1 <= mem1[A_1];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, predict from the memory/queue model, check bank port and return.
    task automatic step(input logic rd, input logic [A_W-1:0] ra,
                        input logic wr, input logic [A_W-1:0] wa, input logic [D_W-1:0] wd);
        logic [40:0]    e_b [2];
        logic [1:0]     busy;
        logic           e_rdy, acc, issue, byp;
        logic [D_W-1:0] e_rd;
        wr_t            h;
        @(negedge clk);
        RD_REQ  = rd;
        RD_ADR  = ra;
        WR_REQ  = wr;
        WR_ADR  = wa;
        WR_DATA = wd;
        #1;
        e_rdy = (q.size() < QD);
        check_eq("wr_rdy", 64'(WR_RDY), 64'(e_rdy));
        check_eq("pend_cnt", 64'(PEND_CNT), 64'(q.size()));
        e_b[0] = '0;
        e_b[1] = '0;
        busy   = '0;
        e_rd   = '0;
        h      = '{adr: '0, data: '0};
        if (rd) begin
            busy[ra[0]] = 1'b1;
            e_b[ra[0]]  = {1'b1, 1'b0, ra[A_W-1:1], 32'h0};
        end
        acc   = wr && e_rdy;
        issue = 1'b0;
        byp   = 1'b0;
        if (q.size() > 0) begin
            h = q[0];
            if (!busy[h.adr[0]]) begin
                issue          = 1'b1;
                e_b[h.adr[0]]  = {1'b1, 1'b1, h.adr[A_W-1:1], h.data};
            end
        end else if (acc && !busy[wa[0]]) begin
            byp        = 1'b1;
            e_b[wa[0]] = {1'b1, 1'b1, wa[A_W-1:1], wd};
        end
        check_eq("bank0", 64'({ENABLE_0, WE_0, A_0, D_0}), 64'(e_b[0]));
        check_eq("bank1", 64'({ENABLE_1, WE_1, A_1, D_1}), 64'(e_b[1]));
        if (rd) begin
            e_rd = ref_ram[ra];
            foreach (q[i]) if (q[i].adr == ra) e_rd = q[i].data;
        end
        if (issue) begin
            ref_ram[h.adr] = h.data;
            h = q.pop_front();
        end
        if (byp) ref_ram[wa] = wd;
        if (acc && !byp) q.push_back('{adr: wa, data: wd});
        @(posedge clk);
        #1;
        check_eq("rd_valid", 64'(RD_VALID), 64'(rd));
        if (rd) last_rd = e_rd;
        check_eq(rd ? "rd_data" : "rd_hold", 64'(RD_DATA), 64'(last_rd));
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        last_rd = '0;
        rst     = 1'b0;
        RD_REQ  = 1'b0;
        RD_ADR  = '0;
        WR_REQ  = 1'b0;
        WR_ADR  = '0;
        WR_DATA = '0;
        for (int a = 0; a < 256; a++) begin
            ref_ram[a] = 32'hAAAA0000 | 32'(a);
            if (a[0]) mem1[a >> 1] = 32'hAAAA0000 | 32'(a);
            else      mem0[a >> 1] = 32'hAAAA0000 | 32'(a);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_pend", 64'(PEND_CNT), 64'd0);
        check_eq("rst_rdy", 64'(WR_RDY), 64'd1);
        check_eq("rst_valid", 64'(RD_VALID), 64'd0);
        check_eq("rst_data", 64'(RD_DATA), 64'd0);
        check_eq("rst_bank0", 64'({ENABLE_0, WE_0}), 64'd0);
        check_eq("rst_bank1", 64'({ENABLE_1, WE_1}), 64'd0);
        rst = 1'b1;

        // Plain read, bypass write, queued write then drain.
        step(1'b1, 8'h04, 1'b0, 8'h00, 32'h0);
        step(1'b1, 8'h04, 1'b1, 8'h05, 32'h11);
        step(1'b1, 8'h06, 1'b1, 8'h08, 32'h22);
        idle();
        // Fill the queue, third write refused, in-order drain.
        step(1'b1, 8'h00, 1'b1, 8'h02, 32'h33);
        step(1'b1, 8'h06, 1'b1, 8'h04, 32'h44);
        step(1'b1, 8'h08, 1'b1, 8'h0A, 32'h99);
        idle();
        idle();
        // Forwarding, including youngest of two entries to one address.
        step(1'b1, 8'h00, 1'b1, 8'h08, 32'h55);
        step(1'b1, 8'h08, 1'b0, 8'h00, 32'h0);
        step(1'b1, 8'h0A, 1'b1, 8'h08, 32'h66);
        step(1'b1, 8'h08, 1'b0, 8'h00, 32'h0);
        idle();
        idle();
        step(1'b1, 8'h08, 1'b0, 8'h00, 32'h0);
        // Same-cycle read and write to one address returns the old value.
        step(1'b1, 8'h0C, 1'b1, 8'h0C, 32'h5A);
        idle();
        step(1'b1, 8'h0C, 1'b0, 8'h00, 32'h0);

        // Reset asserted mid-drain with two queued writes.
        step(1'b1, 8'h00, 1'b1, 8'h02, 32'h77);
        step(1'b1, 8'h04, 1'b1, 8'h06, 32'h88);
        @(negedge clk);
        RD_REQ = 1'b0;
        WR_REQ = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_pend", 64'(PEND_CNT), 64'd0);
        check_eq("arst_rdy", 64'(WR_RDY), 64'd1);
        check_eq("arst_valid", 64'(RD_VALID), 64'd0);
        check_eq("arst_data", 64'(RD_DATA), 64'd0);
        check_eq("arst_bank0", 64'({ENABLE_0, WE_0}), 64'd0);
        check_eq("arst_bank1", 64'({ENABLE_1, WE_1}), 64'd0);
        q.delete();
        last_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        idle();
        idle();
        idle();
        step(1'b1, 8'h02, 1'b0, 8'h00, 32'h0);
        step(1'b1, 8'h06, 1'b0, 8'h00, 32'h0);

        // Random traffic over a narrow address range to force collisions and forwarding.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
